// File: rtl/ctrl_unit_pipe_if.sv
// Decode-to-Execute control bus of the RV32 decode/control block.
// The master side is the pipeline front end; the slave side is ctrl_unit_pipe.
interface ctrl_unit_pipe_if #(
    parameter int unsigned OP_WIDTH     = 7,
    parameter int unsigned FUNCT3_WIDTH = 3,
    parameter int unsigned FUNCT7_WIDTH = 7
);
    logic [OP_WIDTH-1:0]     i_OP_D;
    logic [FUNCT3_WIDTH-1:0] i_FUNCT3_D;
    logic [FUNCT7_WIDTH-1:0] i_FUNCT7_D;
    logic                    i_Valid_D;
    logic                    i_Bubble_E;
    logic                    i_Flush_E;

    logic [2:0]              o_immSrc_D;
    logic                    o_RegWrite_E;
    logic [1:0]              o_ResultSrc_E;
    logic                    o_MemWrite_E;
    logic                    o_Jump_E;
    logic                    o_Branch_E;
    logic                    o_ALUSrc_E;
    logic                    o_LUI_E;
    logic                    o_JalR_E;
    logic [3:0]              o_ALU_Control_E;
    logic                    o_MD_E;
    logic [2:0]              o_MD_Op_E;
    logic                    o_MD_Done_E;
    logic                    o_Valid_E;
    logic                    o_Illegal_E;
    logic                    o_Stall_MD;

    modport master (
        output i_OP_D, i_FUNCT3_D, i_FUNCT7_D, i_Valid_D, i_Bubble_E, i_Flush_E,
        input  o_immSrc_D, o_RegWrite_E, o_ResultSrc_E, o_MemWrite_E, o_Jump_E, o_Branch_E,
        input  o_ALUSrc_E, o_LUI_E, o_JalR_E, o_ALU_Control_E, o_MD_E, o_MD_Op_E,
        input  o_MD_Done_E, o_Valid_E, o_Illegal_E, o_Stall_MD
    );

    modport slave (
        input  i_OP_D, i_FUNCT3_D, i_FUNCT7_D, i_Valid_D, i_Bubble_E, i_Flush_E,
        output o_immSrc_D, o_RegWrite_E, o_ResultSrc_E, o_MemWrite_E, o_Jump_E, o_Branch_E,
        output o_ALUSrc_E, o_LUI_E, o_JalR_E, o_ALU_Control_E, o_MD_E, o_MD_Op_E,
        output o_MD_Done_E, o_Valid_E, o_Illegal_E, o_Stall_MD
    );
endinterface

// File: rtl/ctrl_unit_pipe.sv
// RV32I/M decoder with a registered D/E control word, bubble/flush support and a
// small FSM that holds Execute for multi-cycle MUL/DIV operations.
module ctrl_unit_pipe #(
    parameter int unsigned OP_WIDTH     = 7,
    parameter int unsigned FUNCT3_WIDTH = 3,
    parameter int unsigned FUNCT7_WIDTH = 7,
    parameter bit          ENABLE_M     = 1'b1,
    parameter int unsigned MUL_LAT      = 3,
    parameter int unsigned DIV_LAT      = 34
) (
    input logic            i_CLK,
    input logic            i_RST,
    ctrl_unit_pipe_if.slave bus
);
    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 1);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_LAT - 1);

    localparam logic [OP_WIDTH-1:0] OpOpImm  = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OpOp     = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OpStore  = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OpLoad   = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OpBranch = OP_WIDTH'(7'b1100011);
    localparam logic [OP_WIDTH-1:0] OpJal    = OP_WIDTH'(7'b1101111);
    localparam logic [OP_WIDTH-1:0] OpJalr   = OP_WIDTH'(7'b1100111);
    localparam logic [OP_WIDTH-1:0] OpLui    = OP_WIDTH'(7'b0110111);
    localparam logic [OP_WIDTH-1:0] OpAuipc  = OP_WIDTH'(7'b0010111);
    localparam logic [FUNCT7_WIDTH-1:0] F7MulDiv = FUNCT7_WIDTH'(7'b0000001);

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSll  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSra  = 4'b0111;
    localparam logic [3:0] AluSlt  = 4'b1000;
    localparam logic [3:0] AluSltu = 4'b1001;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic       lui;
        logic       jalr;
        logic [3:0] alu_ctrl;
        logic       md;
        logic [2:0] md_op;
        logic       valid;
        logic       illegal;
    } ctrl_t;

    typedef enum logic [0:0] {StIdle, StMdBusy} state_e;

    logic [OP_WIDTH-1:0]     op;
    logic [FUNCT3_WIDTH-1:0] f3;
    logic [FUNCT7_WIDTH-1:0] f7;
    logic                    is_op_reg;
    logic                    is_md_enc;
    logic [3:0]              alu_f3;
    logic [2:0]              imm_src;
    ctrl_t                   dec;
    ctrl_t                   e_q, e_d;
    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [CntW-1:0]         load_val;
    logic                    stall;

    assign op        = bus.i_OP_D;
    assign f3        = bus.i_FUNCT3_D;
    assign f7        = bus.i_FUNCT7_D;
    assign is_op_reg = (op == OpOp);
    assign is_md_enc = is_op_reg && (f7 == F7MulDiv);

    // funct7[5] selects SUB only for register-register ops; SRA for both forms.
    always_comb begin
        alu_f3 = AluAdd;
        unique case (f3[2:0])
            3'b000: alu_f3 = (is_op_reg && f7[5]) ? AluSub : AluAdd;
            3'b001: alu_f3 = AluSll;
            3'b010: alu_f3 = AluSlt;
            3'b011: alu_f3 = AluSltu;
            3'b100: alu_f3 = AluXor;
            3'b101: alu_f3 = f7[5] ? AluSra : AluSrl;
            3'b110: alu_f3 = AluOr;
            3'b111: alu_f3 = AluAnd;
            default: alu_f3 = AluAdd;
        endcase
    end

    always_comb begin
        dec     = '0;
        imm_src = ImmI;
        case (op)
            OpOpImm: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_f3;
            end
            OpOp: begin
                if (is_md_enc) begin
                    if (ENABLE_M) begin
                        dec.reg_write = 1'b1;
                        dec.md        = 1'b1;
                        dec.md_op     = f3[2:0];
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end else begin
                    dec.reg_write = 1'b1;
                    dec.alu_ctrl  = alu_f3;
                end
            end
            OpStore: begin
                dec.result_src = 2'b01;
                dec.mem_write  = 1'b1;
                dec.alu_src    = 1'b1;
                imm_src        = ImmS;
            end
            OpLoad: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b01;
                dec.alu_src    = 1'b1;
            end
            OpBranch: begin
                dec.result_src = 2'b01;
                dec.branch     = 1'b1;
                dec.alu_ctrl   = AluSub;
                imm_src        = ImmB;
            end
            OpJal: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                dec.alu_src    = 1'b1;
                imm_src        = ImmJ;
            end
            OpJalr: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
            end
            OpLui: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.lui       = 1'b1;
                imm_src       = ImmU;
            end
            OpAuipc: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b11;
                dec.alu_src    = 1'b1;
                imm_src        = ImmU;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            imm_src = ImmI;
        end
        dec.valid = bus.i_Valid_D;
    end

    assign stall = (state_q == StMdBusy) && (cnt_q != '0);

    always_comb begin
        e_d      = e_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_val = dec.md_op[2] ? DivLoad : MulLoad;
        if (bus.i_Flush_E) begin
            e_d     = '0;
            state_d = StIdle;
            cnt_d   = '0;
        end else if (stall) begin
            cnt_d = cnt_q - CntW'(1);
        end else if (bus.i_Bubble_E || !bus.i_Valid_D) begin
            e_d     = '0;
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            e_d     = dec;
            state_d = StIdle;
            cnt_d   = '0;
            if (dec.md) begin
                cnt_d   = load_val;
                state_d = (load_val != '0) ? StMdBusy : StIdle;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            e_q     <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            e_q     <= e_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_immSrc_D      = imm_src;
    assign bus.o_RegWrite_E    = e_q.reg_write;
    assign bus.o_ResultSrc_E   = e_q.result_src;
    assign bus.o_MemWrite_E    = e_q.mem_write;
    assign bus.o_Jump_E        = e_q.jump;
    assign bus.o_Branch_E      = e_q.branch;
    assign bus.o_ALUSrc_E      = e_q.alu_src;
    assign bus.o_LUI_E         = e_q.lui;
    assign bus.o_JalR_E        = e_q.jalr;
    assign bus.o_ALU_Control_E = e_q.alu_ctrl;
    assign bus.o_MD_E          = e_q.md;
    assign bus.o_MD_Op_E       = e_q.md_op;
    assign bus.o_MD_Done_E     = e_q.md && e_q.valid && (cnt_q == '0);
    assign bus.o_Valid_E       = e_q.valid;
    assign bus.o_Illegal_E     = e_q.illegal;
    assign bus.o_Stall_MD      = stall;
endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Directed bench for ctrl_unit_pipe: decode table, MUL/DIV sequencing, priorities, reset.
// A second instance with the M extension disabled checks the illegal-M path.
module tb_ctrl_unit_pipe;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] BADOP  = 7'b1111111;
    localparam logic [6:0] F7M    = 7'b0000001;
    localparam logic [6:0] F7ALT  = 7'b0100000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   ns;
    logic seen;

    ctrl_unit_pipe_if ifm ();
    ctrl_unit_pipe_if ifn ();

    ctrl_unit_pipe #(.ENABLE_M(1'b1), .MUL_LAT(3), .DIV_LAT(34)) u_dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (ifm)
    );

    ctrl_unit_pipe #(.ENABLE_M(1'b0), .MUL_LAT(3), .DIV_LAT(34)) u_dut_nom (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (ifn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] e_word, n_word;
    assign e_word = {ifm.o_RegWrite_E, ifm.o_ResultSrc_E, ifm.o_MemWrite_E, ifm.o_Jump_E,
                     ifm.o_Branch_E, ifm.o_ALUSrc_E, ifm.o_LUI_E, ifm.o_JalR_E,
                     ifm.o_ALU_Control_E, ifm.o_MD_E, ifm.o_MD_Op_E, ifm.o_Valid_E,
                     ifm.o_Illegal_E};
    assign n_word = {ifn.o_RegWrite_E, ifn.o_ResultSrc_E, ifn.o_MemWrite_E, ifn.o_Jump_E,
                     ifn.o_Branch_E, ifn.o_ALUSrc_E, ifn.o_LUI_E, ifn.o_JalR_E,
                     ifn.o_ALU_Control_E, ifn.o_MD_E, ifn.o_MD_Op_E, ifn.o_Valid_E,
                     ifn.o_Illegal_E};

    // Field order: rw, result_src, mw, jump, branch, alu_src, lui, jalr, alu, md, md_op, v, ill
    function automatic logic [18:0] ew(input logic rw, input logic [1:0] rs, input logic mw,
                                       input logic j, input logic b, input logic as,
                                       input logic lui, input logic jr, input logic [3:0] alu,
                                       input logic md, input logic [2:0] mdop, input logic v,
                                       input logic ill);
        return {rw, rs, mw, j, b, as, lui, jr, alu, md, mdop, v, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic v, input logic bub, input logic fl);
        ifm.i_OP_D = op;  ifm.i_FUNCT3_D = f3;  ifm.i_FUNCT7_D = f7;
        ifm.i_Valid_D = v; ifm.i_Bubble_E = bub; ifm.i_Flush_E = fl;
        ifn.i_OP_D = op;  ifn.i_FUNCT3_D = f3;  ifn.i_FUNCT7_D = f7;
        ifn.i_Valid_D = v; ifn.i_Bubble_E = bub; ifn.i_Flush_E = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec_case(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [2:0] imm,
                            input logic [18:0] word);
        drive(op, f3, f7, 1'b1, 1'b0, 1'b0);
        check({tag, "_imm"}, ifm.o_immSrc_D, imm);
        tick();
        check(tag, e_word, word);
    endtask

    localparam logic [18:0] ADDW = 19'({1'b1, 2'b00, 5'b0, 1'b0, 4'b0000, 1'b0, 3'b0, 1'b1, 1'b0});

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(OP, 3'b000, 7'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_e", e_word, 19'd0);
        check("rst_stall", ifm.o_Stall_MD, 1'b0);
        rst = 1'b0;

        dec_case("sub",   OP,     3'b000, F7ALT, 3'b000, ew(1,2'b00,0,0,0,0,0,0,4'b0001,0,3'b0,1,0));
        dec_case("add",   OP,     3'b000, 7'b0,  3'b000, ew(1,2'b00,0,0,0,0,0,0,4'b0000,0,3'b0,1,0));
        dec_case("and",   OP,     3'b111, 7'b0,  3'b000, ew(1,2'b00,0,0,0,0,0,0,4'b0010,0,3'b0,1,0));
        dec_case("sltu",  OP,     3'b011, 7'b0,  3'b000, ew(1,2'b00,0,0,0,0,0,0,4'b1001,0,3'b0,1,0));
        dec_case("sra",   OP,     3'b101, F7ALT, 3'b000, ew(1,2'b00,0,0,0,0,0,0,4'b0111,0,3'b0,1,0));
        dec_case("addi",  OPIMM,  3'b000, F7ALT, 3'b000, ew(1,2'b00,0,0,0,1,0,0,4'b0000,0,3'b0,1,0));
        dec_case("srai",  OPIMM,  3'b101, F7ALT, 3'b000, ew(1,2'b00,0,0,0,1,0,0,4'b0111,0,3'b0,1,0));
        dec_case("slli",  OPIMM,  3'b001, 7'b0,  3'b000, ew(1,2'b00,0,0,0,1,0,0,4'b0101,0,3'b0,1,0));
        dec_case("load",  LOAD,   3'b010, 7'b0,  3'b000, ew(1,2'b01,0,0,0,1,0,0,4'b0000,0,3'b0,1,0));
        dec_case("store", STORE,  3'b010, 7'b0,  3'b001, ew(0,2'b01,1,0,0,1,0,0,4'b0000,0,3'b0,1,0));
        dec_case("beq",   BRANCH, 3'b000, 7'b0,  3'b010, ew(0,2'b01,0,0,1,0,0,0,4'b0001,0,3'b0,1,0));
        dec_case("jal",   JAL,    3'b000, 7'b0,  3'b011, ew(1,2'b10,0,1,0,1,0,0,4'b0000,0,3'b0,1,0));
        dec_case("jalr",  JALR,   3'b000, 7'b0,  3'b000, ew(1,2'b10,0,1,0,0,0,1,4'b0000,0,3'b0,1,0));
        dec_case("lui",   LUI,    3'b000, 7'b0,  3'b100, ew(1,2'b00,0,0,0,1,1,0,4'b0000,0,3'b0,1,0));
        dec_case("auipc", AUIPC,  3'b000, 7'b0,  3'b100, ew(1,2'b11,0,0,0,1,0,0,4'b0000,0,3'b0,1,0));
        dec_case("illegal", BADOP, 3'b000, 7'b0, 3'b000, ew(0,2'b00,0,0,0,0,0,0,4'b0000,0,3'b0,1,1));

        drive(LOAD, 3'b010, 7'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("invalid_d", e_word, 19'd0);

        // MUL: 3 cycles in E, stall for the first 2; bubble request is ignored while stalled
        drive(OP, 3'b000, F7M, 1'b1, 1'b0, 1'b0);
        tick();
        check("mul_t0", e_word, ew(1,2'b00,0,0,0,0,0,0,4'b0000,1,3'b000,1,0));
        check("mul_t0_stall", ifm.o_Stall_MD, 1'b1);
        check("mul_t0_done", ifm.o_MD_Done_E, 1'b0);
        check("nom_mul", n_word, ew(0,2'b00,0,0,0,0,0,0,4'b0000,0,3'b0,1,1));
        check("nom_mul_stall", ifn.o_Stall_MD, 1'b0);
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("mul_t1_hold", e_word, ew(1,2'b00,0,0,0,0,0,0,4'b0000,1,3'b000,1,0));
        check("mul_t1_stall", ifm.o_Stall_MD, 1'b1);
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("mul_t2_stall", ifm.o_Stall_MD, 1'b0);
        check("mul_t2_done", ifm.o_MD_Done_E, 1'b1);
        check("mul_t2_word", e_word, ew(1,2'b00,0,0,0,0,0,0,4'b0000,1,3'b000,1,0));
        tick();
        check("mul_t3_next", e_word, ADDW);
        check("mul_t3_done", ifm.o_MD_Done_E, 1'b0);

        // Back-to-back MULHU restarts the counter without an idle cycle
        drive(OP, 3'b011, F7M, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("b2b_done", ifm.o_MD_Done_E, 1'b1);
        tick();
        check("b2b_restart", ifm.o_Stall_MD, 1'b1);
        check("b2b_op", ifm.o_MD_Op_E, 3'b011);
        check("b2b_done2", ifm.o_MD_Done_E, 1'b0);
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check("b2b_done3", ifm.o_MD_Done_E, 1'b1);
        tick();
        check("b2b_after", e_word, ADDW);

        // DIV aborted by a flush: bubble, no stall, no Done ever
        drive(OP, 3'b100, F7M, 1'b1, 1'b0, 1'b0);
        tick();
        check("div_t0", e_word, ew(1,2'b00,0,0,0,0,0,0,4'b0000,1,3'b100,1,0));
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        check("div_t5_stall", ifm.o_Stall_MD, 1'b1);
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check("flush_e", e_word, 19'd0);
        check("flush_stall", ifm.o_Stall_MD, 1'b0);
        check("flush_done", ifm.o_MD_Done_E, 1'b0);
        drive(OP, 3'b000, 7'b0, 1'b0, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen = seen | ifm.o_MD_Done_E;
        end
        check("flush_no_done", seen, 1'b0);

        // Bubble with stall low, and flush+bubble together
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("pre_bubble", e_word, ADDW);
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("bubble", e_word, 19'd0);
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check("flush_bubble", e_word, 19'd0);

        // REMU runs the full DIV latency: 34 E cycles, 33 of them stalled
        drive(OP, 3'b111, F7M, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b0, 1'b0);
        cyc = 0;
        ns  = 0;
        while (ifm.o_MD_Done_E !== 1'b1 && cyc < 60) begin
            if (ifm.o_Stall_MD) ns++;
            tick();
            cyc++;
        end
        check("div_lat", cyc, 33);
        check("div_stalls", ns, 33);
        tick();
        check("div_after", e_word, ADDW);

        // Reset for two cycles in the middle of a DIV
        drive(OP, 3'b101, F7M, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OP, 3'b000, 7'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_e", e_word, 19'd0);
        tick();
        check("rst_mid_stall", ifm.o_Stall_MD, 1'b0);
        check("rst_mid_done", ifm.o_MD_Done_E, 1'b0);
        rst = 1'b0;
        drive(OP, 3'b000, 7'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("post_rst_e", e_word, 19'd0);
        check("post_rst_stall", ifm.o_Stall_MD, 1'b0);
        drive(OP, 3'b000, F7M, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_rst_mul", ifm.o_Stall_MD, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
